slave_mailbox: RTL

Bus responder that terminates the serial master/bus protocol at a byte-wide mailbox FIFO. Masters push bytes by writing the data register and pop them by reading it; a status register reports fill level and sticky error flags. Attaches to one slave port of `bus` (AD_SEL / B_ACK / B_RW / B_SBSY / B_READY / B_BUS_IN / B_BUS_OUT) alongside `slave_4K` and `slave_2K`.

---
 rtl/bus_pkg.sv | 25 ++
 rtl/mailbox_fifo.sv | 76 +++++++
 rtl/slave_mailbox.sv | 196 +++++++++++++++++++
 3 files changed

// File: rtl/bus_pkg.sv
// Shared definitions for the mailbox slave: FSM states, register map and
// status byte layout.
package bus_pkg;

    localparam int ADDR_W_DEF = 11;

    localparam int REG_DATA   = 0;
    localparam int REG_STATUS = 1;

    localparam int STAT_FULL  = 7;
    localparam int STAT_EMPTY = 6;
    localparam int STAT_OVF   = 5;
    localparam int STAT_UNF   = 4;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_ADDR    = 3'd1,
        ST_ACK     = 3'd2,
        ST_WDATA   = 3'd3,
        ST_WCOMMIT = 3'd4,
        ST_RPREP   = 3'd5,
        ST_RDATA   = 3'd6
    } state_e;

endpackage

// File: rtl/mailbox_fifo.sv
// Byte-wide synchronous FIFO with flush; push on full and pop on empty are
// ignored here, the caller decides how to flag them.
module mailbox_fifo #(
    parameter int DEPTH = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       push,
    input  logic       pop,
    input  logic       flush,
    input  logic [7:0] din,
    output logic [7:0] dout,
    output logic [3:0] count,
    output logic       full,
    output logic       empty
);

    localparam int PW = $clog2(DEPTH);

    logic [7:0]    mem_q [DEPTH];
    logic [7:0]    mem_d [DEPTH];
    logic [PW-1:0] wr_q, wr_d;
    logic [PW-1:0] rd_q, rd_d;
    logic [3:0]    cnt_q, cnt_d;
    logic          do_push, do_pop;

    // Pointers wrap at DEPTH, which need not be a power of two.
    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign full    = (cnt_q == 4'(DEPTH));
    assign empty   = (cnt_q == 4'd0);
    assign count   = cnt_q;
    assign dout    = mem_q[rd_q];
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    always_comb begin
        mem_d = mem_q;
        wr_d  = wr_q;
        rd_d  = rd_q;
        cnt_d = cnt_q;
        if (flush) begin
            wr_d  = '0;
            rd_d  = '0;
            cnt_d = 4'd0;
        end else begin
            if (do_push) begin
                mem_d[wr_q] = din;
                wr_d        = ptr_inc(wr_q);
            end
            if (do_pop) begin
                rd_d = ptr_inc(rd_q);
            end
            cnt_d = cnt_q + 4'(do_push) - 4'(do_pop);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= 8'h00;
            end
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= 4'd0;
        end else begin
            mem_q <= mem_d;
            wr_q  <= wr_d;
            rd_q  <= rd_d;
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/slave_mailbox.sv
// Serial bus slave exposing a byte mailbox FIFO through a DATA register
// (push/pop) and a STATUS register (level, sticky overflow/underflow).
module slave_mailbox
    import bus_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DEPTH  = 8
) (
    input  logic       CLK,
    input  logic       RSTN,
    input  logic       AD_SEL,
    input  logic       B_RW,
    input  logic       B_BUS_IN,
    output logic       B_BUS_OUT,
    output logic       B_ACK,
    output logic       B_SBSY,
    output logic       B_READY,
    output logic       S_DVALID,
    output logic [7:0] S_DOUT,
    output logic [3:0] S_COUNT
);

    // One counter serves the address phase and both 8-bit data phases.
    localparam int CW = $clog2(((ADDR_W > 8) ? ADDR_W : 8) + 1);

    state_e            state_q, state_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              rw_q, rw_d;
    logic [7:0]        wsh_q, wsh_d;
    logic [7:0]        rsh_q, rsh_d;
    logic [7:0]        dout_q, dout_d;
    logic              ovf_q, ovf_d;
    logic              unf_q, unf_d;

    logic              fifo_push, fifo_pop, fifo_flush;
    logic [7:0]        fifo_dout;
    logic [3:0]        fifo_count;
    logic              fifo_full, fifo_empty;
    logic              is_data, is_status;
    logic [7:0]        status_byte;

    mailbox_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk   (CLK),
        .rst_n (RSTN),
        .push  (fifo_push),
        .pop   (fifo_pop),
        .flush (fifo_flush),
        .din   (wsh_q),
        .dout  (fifo_dout),
        .count (fifo_count),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    assign is_data   = (addr_q == ADDR_W'(REG_DATA));
    assign is_status = (addr_q == ADDR_W'(REG_STATUS));

    always_comb begin
        status_byte             = 8'h00;
        status_byte[STAT_FULL]  = fifo_full;
        status_byte[STAT_EMPTY] = fifo_empty;
        status_byte[STAT_OVF]   = ovf_q;
        status_byte[STAT_UNF]   = unf_q;
        status_byte[3:0]        = fifo_count;
    end

    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:    if (AD_SEL) state_d = ST_ADDR;
            ST_ADDR: begin
                if (!AD_SEL) begin
                    state_d = ST_IDLE;
                end else if (cnt_q == CW'(ADDR_W - 1)) begin
                    state_d = ST_ACK;
                end
            end
            ST_ACK:     state_d = rw_q ? ST_WDATA : ST_RPREP;
            ST_WDATA:   if (cnt_q == CW'(7)) state_d = ST_WCOMMIT;
            ST_WCOMMIT: state_d = ST_IDLE;
            ST_RPREP:   state_d = ST_RDATA;
            ST_RDATA:   if (cnt_q == CW'(7)) state_d = ST_IDLE;
            default:    state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        B_ACK     = (state_q == ST_ACK);
        B_SBSY    = (state_q != ST_IDLE);
        B_READY   = (state_q == ST_RDATA);
        B_BUS_OUT = (state_q == ST_RDATA) && rsh_q[0];
        S_DVALID  = (state_q == ST_WCOMMIT);
    end

    assign S_DOUT  = dout_q;
    assign S_COUNT = fifo_count;

    always_comb begin
        cnt_d      = cnt_q;
        addr_d     = addr_q;
        rw_d       = rw_q;
        wsh_d      = wsh_q;
        rsh_d      = rsh_q;
        dout_d     = dout_q;
        ovf_d      = ovf_q;
        unf_d      = unf_q;
        fifo_push  = 1'b0;
        fifo_pop   = 1'b0;
        fifo_flush = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (AD_SEL) begin
                    addr_d = {B_BUS_IN, addr_q[ADDR_W-1:1]};
                    rw_d   = B_RW;
                    cnt_d  = CW'(1);
                end
            end
            ST_ADDR: begin
                if (AD_SEL) begin
                    addr_d = {B_BUS_IN, addr_q[ADDR_W-1:1]};
                    cnt_d  = cnt_q + 1'b1;
                end
            end
            ST_ACK: cnt_d = '0;
            ST_WDATA: begin
                wsh_d = {B_BUS_IN, wsh_q[7:1]};
                cnt_d = cnt_q + 1'b1;
            end
            ST_WCOMMIT: begin
                dout_d = wsh_q;
                if (is_data) begin
                    if (fifo_full) ovf_d = 1'b1;
                    else           fifo_push = 1'b1;
                end else if (is_status) begin
                    fifo_flush = 1'b1;
                    ovf_d      = 1'b0;
                    unf_d      = 1'b0;
                end
            end
            ST_RPREP: begin
                cnt_d = '0;
                rsh_d = 8'h00;
                if (is_data) begin
                    if (fifo_empty) begin
                        unf_d = 1'b1;
                    end else begin
                        rsh_d    = fifo_dout;
                        fifo_pop = 1'b1;
                    end
                end else if (is_status) begin
                    // Flags are reported in this byte, then cleared.
                    rsh_d = status_byte;
                    ovf_d = 1'b0;
                    unf_d = 1'b0;
                end
            end
            ST_RDATA: begin
                rsh_d = {1'b0, rsh_q[7:1]};
                cnt_d = cnt_q + 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            cnt_q  <= '0;
            addr_q <= '0;
            rw_q   <= 1'b0;
            wsh_q  <= 8'h00;
            rsh_q  <= 8'h00;
            dout_q <= 8'h00;
            ovf_q  <= 1'b0;
            unf_q  <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            addr_q <= addr_d;
            rw_q   <= rw_d;
            wsh_q  <= wsh_d;
            rsh_q  <= rsh_d;
            dout_q <= dout_d;
            ovf_q  <= ovf_d;
            unf_q  <= unf_d;
        end
    end

endmodule
